port_batch_buffer: RTL and testbench
====================================

// Module: port_batch_buffer
// PURPOSE
//  Stage directly downstream of the per-port frame parser. Collects parsed words into
//  8-word batches in a two-bank ping-pong buffer, tags each batch with dest port/priority,
//  and bursts full or packet-final batches to the SRAM writer via a req/gnt handshake.
//  One instance per ingress port; parser has no backpressure, so overflow drops words.
// PARAMETERS
//  DATA_W  16  data word width
//  DEPTH   8   words per batch (bank depth); CNT_W = $clog2(DEPTH)+1
//  PORT_W  4   destination port field width
//  PRI_W   3   priority field width
// PORTS
//  clk        in   1       single clock
//  rst_n      in   1       reset, synchronous, active-low
//  in_vld     in   1       parser word valid (parser 'writting')
//  in_ctrl    in   1       word is the packet control (header) word
//  in_eop     in   1       word is the last of the packet (coincident with in_vld)
//  in_dest    in   PORT_W  destination port, valid with in_ctrl
//  in_prior   in   PRI_W   priority, valid with in_ctrl
//  in_data    in   DATA_W  word payload (header word stored as payload too)
//  out_req    out  1       batch ready; header outputs stable while high
//  out_gnt    in   1       SRAM writer accepts request
//  out_dest   out  PORT_W  batch destination port
//  out_prior  out  PRI_W   batch priority
//  out_cnt    out  CNT_W   words in batch, 1..DEPTH
//  out_last   out  1       batch holds packet's final word
//  out_vld    out  1       burst beat valid
//  out_data   out  DATA_W  burst beat data, word 0 first
//  err_ovf    out  1       sticky: words dropped for lack of a free bank
//  err_proto  out  1       sticky: in_ctrl seen mid-packet
// BEHAVIOUR
//  Reset: all outputs 0; both banks FREE; write bank=0, read bank=0, wr ptr=0, not in packet.
//  Bank states FREE->FILL->CLOSED->DRAIN->FREE. Write bank takes words at ptr, ptr++.
//  in_ctrl: latch in_dest/in_prior into header regs; header persists for all banks of pkt.
//  Close: on write of word DEPTH-1 or in_eop: cnt=ptr+1, last=in_eop, header copied to bank,
//   bank->CLOSED, write bank toggles, ptr=0. Close and free of other bank in same cycle:
//   freed bank counts as available (no drop).
//  Overflow: word arrives and write bank not FREE/FILL -> word dropped, err_ovf=1, drop mode
//   until in_eop inclusive; next packet accepted from its in_ctrl if a bank is free.
//  in_ctrl while in packet: err_proto=1; header updated, word stored as normal data.
//  in_vld without in_ctrl while not in packet: word stored, header regs unchanged.
//  Drain FSM IDLE/REQ/BURST. IDLE: read bank CLOSED -> REQ. REQ: out_req=1, header outputs
//   from read bank; out_gnt=1 sampled -> BURST. BURST: out_vld=1 for out_cnt beats,
//   out_data=bank[i]; last beat frees bank, toggles read bank, -> IDLE (1 idle cycle min).
//  Latency: closing write at edge t -> out_req high from t+2; first beat cycle after gnt.
//  Banks drain strictly in close order (alternating). out_gnt ignored outside REQ.
//  Reset mid-operation: next cycle out_req=out_vld=0, burst abandoned, contents discarded.
// STRUCTURE
//  port_pkg: DATA_W/DEPTH/PORT_W/PRI_W constants, bank_state_e {FREE,FILL,CLOSED,DRAIN},
//   drain_state_e {IDLE,REQ,BURST}, batch_hdr_t {dest,prior,cnt,last}.
//  Sub-module batch_bank: DEPTH x DATA_W regfile + batch_hdr_t + state; two instances.
// TESTING
//  ctrl(dest=5,prior=3)+9 data, gnt tied 1 -> bursts cnt=8 last=0 then cnt=2 last=1, dest 5 prior 3, data in order.
//  3-word packet, gnt=1 -> one burst cnt=3 last=1; out_req rises 2 cycles after eop word.
//  gnt=0, 24-word packet -> words 0..15 held, 16..23 dropped, err_ovf=1; on gnt bursts 8/8, last=0.
//  Two 5-word packets back-to-back, gnt 1 cycle late -> bursts in order, each cnt=5 last=1, own header.
//  rst_n=0 on beat 4 of 8-beat burst -> next cycle out_vld=0, out_req=0; fresh packet then drains normally.
//  in_ctrl on word 3 of open packet -> err_proto=1, header switches, word counts toward current batch.

Source files
------------

// File: rtl/port_batch_buffer_pkg.sv
// port_batch_buffer_pkg: shared constants, bank/drain state encodings and batch header layout
package port_batch_buffer_pkg;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int PORT_W = 4;
    localparam int PRI_W  = 3;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int AW     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);
    typedef enum logic [1:0] {FREE, FILL, CLOSED, DRAIN} bank_state_e;
    typedef enum logic [1:0] {IDLE, REQ, BURST} drain_state_e;
    typedef struct packed {
        logic [PORT_W-1:0] dest;
        logic [PRI_W-1:0]  prior;
        logic [CNT_W-1:0]  cnt;
        logic              last;
    } batch_hdr_t;
endpackage

// File: rtl/port_batch_buffer_bank.sv
// port_batch_buffer_bank: one ping-pong bank holding a batch of words, its header and lifecycle state
module port_batch_buffer_bank
    import port_batch_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr,
    input  logic              i_close,
    input  logic              i_drain,
    input  logic              i_free,
    input  logic [AW-1:0]     i_waddr,
    input  logic [AW-1:0]     i_raddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  batch_hdr_t        i_hdr,
    output bank_state_e       o_state,
    output batch_hdr_t        o_hdr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    bank_state_e       r_state;
    batch_hdr_t        r_hdr;

    always_ff @(posedge clk) if (i_wr) r_mem[i_waddr] <= i_wdata;

    // a write may coincide with the final drain beat; the new fill wins over the free
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FREE;
            r_hdr   <= '0;
        end else begin
            r_state <= i_wr ? (i_close ? CLOSED : FILL) : i_drain ? DRAIN : i_free ? FREE : r_state;
            if (i_wr && i_close) r_hdr <= i_hdr;
        end
    end

    assign o_state = r_state;
    assign o_hdr   = r_hdr;
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/port_batch_buffer.sv
// port_batch_buffer: batches parser words into two ping-pong banks and bursts them to the SRAM writer
module port_batch_buffer
    import port_batch_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic              in_ctrl,
    input  logic              in_eop,
    input  logic [PORT_W-1:0] in_dest,
    input  logic [PRI_W-1:0]  in_prior,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_req,
    input  logic              out_gnt,
    output logic [PORT_W-1:0] out_dest,
    output logic [PRI_W-1:0]  out_prior,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_last,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data,
    output logic              err_ovf,
    output logic              err_proto
);
    logic              r_wr_bank, r_rd_bank, r_in_pkt, r_drop, r_ovf, r_proto;
    logic [CNT_W-1:0]  r_ptr, r_beat;
    logic [PORT_W-1:0] r_dest;
    logic [PRI_W-1:0]  r_prior;
    drain_state_e      r_dst;
    bank_state_e       w_state [2];
    batch_hdr_t        w_hdr [2];
    logic [DATA_W-1:0] w_rdata [2];
    batch_hdr_t        w_rd_hdr, w_new_hdr;
    logic              w_free, w_avail, w_drop, w_wr, w_close, w_busy;

    assign w_rd_hdr  = w_hdr[r_rd_bank];
    assign w_free    = r_dst == BURST && r_beat == w_rd_hdr.cnt - ONE;
    // a bank emptying on this very cycle can take the incoming word
    assign w_avail   = w_state[r_wr_bank] == FREE || w_state[r_wr_bank] == FILL ||
                       (w_state[r_wr_bank] == DRAIN && w_free);
    assign w_drop    = in_vld && (r_drop || !w_avail);
    assign w_wr      = in_vld && !w_drop;
    assign w_close   = w_wr && (in_eop || r_ptr == LAST_IDX);
    assign w_new_hdr = '{dest: in_ctrl ? in_dest : r_dest, prior: in_ctrl ? in_prior : r_prior,
                         cnt: r_ptr + ONE, last: in_eop};

    for (genvar g = 0; g < 2; g++) begin : g_bank
        port_batch_buffer_bank u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_wr    (w_wr && r_wr_bank == 1'(g)),
            .i_close (w_close),
            .i_drain (r_dst == REQ && out_gnt && r_rd_bank == 1'(g)),
            .i_free  (w_free && r_rd_bank == 1'(g)),
            .i_waddr (r_ptr[AW-1:0]),
            .i_raddr (r_beat[AW-1:0]),
            .i_wdata (in_data),
            .i_hdr   (w_new_hdr),
            .o_state (w_state[g]),
            .o_hdr   (w_hdr[g]),
            .o_rdata (w_rdata[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_in_pkt  <= 1'b0;
            r_drop    <= 1'b0;
            r_ovf     <= 1'b0;
            r_proto   <= 1'b0;
            r_ptr     <= '0;
            r_beat    <= '0;
            r_dest    <= '0;
            r_prior   <= '0;
            r_dst     <= IDLE;
        end else begin
            if (w_wr) r_ptr <= w_close ? '0 : r_ptr + ONE;
            if (w_close) r_wr_bank <= ~r_wr_bank;
            if (in_vld) begin
                r_in_pkt <= !in_eop;
                r_drop   <= w_drop && !in_eop;
            end
            if (in_vld && in_ctrl) begin
                r_dest  <= in_dest;
                r_prior <= in_prior;
            end
            if (in_vld && in_ctrl && r_in_pkt) r_proto <= 1'b1;
            if (w_drop) r_ovf <= 1'b1;
            r_dst     <= r_dst == IDLE ? (w_state[r_rd_bank] == CLOSED ? REQ : IDLE) :
                         r_dst == REQ  ? (out_gnt ? BURST : REQ) : (w_free ? IDLE : BURST);
            r_beat    <= r_dst == BURST ? r_beat + ONE : '0;
            r_rd_bank <= r_rd_bank ^ w_free;
        end
    end

    assign w_busy    = r_dst != IDLE;
    assign out_req   = r_dst == REQ;
    assign out_vld   = r_dst == BURST;
    assign out_dest  = w_busy ? w_rd_hdr.dest : '0;
    assign out_prior = w_busy ? w_rd_hdr.prior : '0;
    assign out_cnt   = w_busy ? w_rd_hdr.cnt : '0;
    assign out_last  = w_busy ? w_rd_hdr.last : 1'b0;
    assign out_data  = out_vld ? w_rdata[r_rd_bank] : '0;
    assign err_ovf   = r_ovf;
    assign err_proto = r_proto;
endmodule

// File: tb/tb_port_batch_buffer.sv
// tb_port_batch_buffer: directed and random traffic scored against a queue-of-batches reference model
module tb_port_batch_buffer;
    import port_batch_buffer_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n, in_vld, in_ctrl, in_eop, out_req, out_gnt, out_last, out_vld, err_ovf, err_proto;
    logic [PORT_W-1:0] in_dest, out_dest;
    logic [PRI_W-1:0]  in_prior, out_prior;
    logic [DATA_W-1:0] in_data, out_data;
    logic [CNT_W-1:0]  out_cnt;

    always #5 clk = ~clk;

    port_batch_buffer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld    (in_vld),
        .in_ctrl   (in_ctrl),
        .in_eop    (in_eop),
        .in_dest   (in_dest),
        .in_prior  (in_prior),
        .in_data   (in_data),
        .out_req   (out_req),
        .out_gnt   (out_gnt),
        .out_dest  (out_dest),
        .out_prior (out_prior),
        .out_cnt   (out_cnt),
        .out_last  (out_last),
        .out_vld   (out_vld),
        .out_data  (out_data),
        .err_ovf   (err_ovf),
        .err_proto (err_proto)
    );

    typedef struct {
        logic [PORT_W-1:0] dest;
        logic [PRI_W-1:0]  prior;
        int                cnt;
        logic              last;
        logic [DATA_W-1:0] d [DEPTH];
    } batch_t;

    batch_t            exp_q [$];
    batch_t            cur;
    int                m_cnt, mon_beat, n_bursts, gnt_mode, n_checks, n_fails;
    logic              m_drop, m_in_pkt, m_ovf, m_proto, hdr_done, prev_req;
    logic [PORT_W-1:0] m_dest;
    logic [PRI_W-1:0]  m_prior;

    task automatic check(string tag, logic [63:0] got, logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        m_cnt    = 0;
        m_drop   = 1'b0;
        m_in_pkt = 1'b0;
        m_ovf    = 1'b0;
        m_proto  = 1'b0;
        m_dest   = '0;
        m_prior  = '0;
        mon_beat = 0;
        hdr_done = 1'b0;
        prev_req = 1'b0;
    endfunction

    // batches occupy banks until fully drained; two outstanding batches means no room
    function automatic void model_step();
        if (!in_vld) return;
        if (in_ctrl && m_in_pkt) m_proto = 1'b1;
        if (in_ctrl) begin
            m_dest  = in_dest;
            m_prior = in_prior;
        end
        if (!m_drop && (m_cnt > 0 || exp_q.size() < 2)) begin
            cur.d[m_cnt] = in_data;
            m_cnt++;
            if (m_cnt == DEPTH || in_eop) begin
                cur.dest  = m_dest;
                cur.prior = m_prior;
                cur.cnt   = m_cnt;
                cur.last  = in_eop;
                exp_q.push_back(cur);
                m_cnt = 0;
            end
        end else begin
            m_ovf  = 1'b1;
            m_drop = !in_eop;
        end
        m_in_pkt = !in_eop;
    endfunction

    task automatic monitor();
        if (out_req && !hdr_done) begin
            if (exp_q.size() == 0) check("spurious_req", 64'(out_req), 64'(0));
            else begin
                check("hdr", 64'({out_dest, out_prior, out_cnt, out_last}),
                      64'({exp_q[0].dest, exp_q[0].prior, CNT_W'(exp_q[0].cnt), exp_q[0].last}));
                hdr_done = 1'b1;
            end
        end
        if (out_vld) begin
            if (exp_q.size() == 0) check("spurious_vld", 64'(out_vld), 64'(0));
            else begin
                check("beat", 64'(out_data), 64'(exp_q[0].d[mon_beat]));
                mon_beat++;
                if (mon_beat == exp_q[0].cnt) begin
                    void'(exp_q.pop_front());
                    mon_beat = 0;
                    hdr_done = 1'b0;
                    n_bursts++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        if (rst_n) monitor();
        out_gnt  = gnt_mode == 1 ? 1'b1 : gnt_mode == 2 ? (out_req && prev_req) :
                   gnt_mode == 3 ? 1'($urandom) : 1'b0;
        prev_req = out_req;
    endtask

    task automatic send_word(logic ctrl, logic eop, logic [PORT_W-1:0] dest, logic [PRI_W-1:0] prior);
        in_vld   = 1'b1;
        in_ctrl  = ctrl;
        in_eop   = eop;
        in_dest  = dest;
        in_prior = prior;
        in_data  = DATA_W'($urandom);
        tick();
    endtask

    task automatic send_pkt(int len, logic [PORT_W-1:0] dest, logic [PRI_W-1:0] prior);
        for (int i = 0; i < len; i++) send_word(i == 0, i == len - 1, dest, prior);
    endtask

    task automatic idle(int n);
        in_vld  = 1'b0;
        in_ctrl = 1'b0;
        in_eop  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain(int budget);
        int n = 0;
        idle(1);
        while ((exp_q.size() != 0 || out_req || out_vld) && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int b0, n;
        n_checks = 0;
        n_fails  = 0;
        n_bursts = 0;
        gnt_mode = 0;
        out_gnt  = 1'b0;
        in_dest  = '0;
        in_prior = '0;
        in_data  = '0;
        do_reset();
        check("rst_outs", 64'({out_req, out_vld, out_data, out_dest, out_prior, out_cnt, out_last, err_ovf, err_proto}), 64'(0));

        gnt_mode = 1;
        b0 = n_bursts;
        send_word(1'b1, 1'b0, 4'd5, 3'd3);
        for (int i = 0; i < 9; i++) send_word(1'b0, i == 8, 4'd0, 3'd0);
        drain(100);
        check("split_bursts", 64'(n_bursts - b0), 64'(2));

        send_pkt(3, 4'd7, 3'd1);
        check("req_not_yet", 64'(out_req), 64'(0));
        idle(1);
        check("req_rise", 64'(out_req), 64'(1));
        drain(100);

        do_reset();
        gnt_mode = 0;
        send_pkt(24, 4'd12, 3'd2);
        idle(3);
        check("ovf_req_held", 64'(out_req), 64'(1));
        check("ovf_flag", 64'(err_ovf), 64'(1));
        check("ovf_queued", 64'(exp_q.size()), 64'(2));
        gnt_mode = 1;
        b0 = n_bursts;
        drain(100);
        check("ovf_bursts", 64'(n_bursts - b0), 64'(2));

        do_reset();
        gnt_mode = 2;
        b0 = n_bursts;
        send_pkt(5, 4'd3, 3'd2);
        send_pkt(5, 4'd11, 3'd4);
        drain(100);
        check("b2b_bursts", 64'(n_bursts - b0), 64'(2));
        check("b2b_proto", 64'(err_proto), 64'(0));

        do_reset();
        gnt_mode = 1;
        send_word(1'b1, 1'b0, 4'd2, 3'd1);
        send_word(1'b0, 1'b0, 4'd0, 3'd0);
        send_word(1'b0, 1'b0, 4'd0, 3'd0);
        send_word(1'b1, 1'b0, 4'd9, 3'd6);
        send_word(1'b0, 1'b0, 4'd0, 3'd0);
        send_word(1'b0, 1'b1, 4'd0, 3'd0);
        drain(100);
        check("proto_flag", 64'(err_proto), 64'(1));
        check("proto_no_ovf", 64'(err_ovf), 64'(0));

        do_reset();
        gnt_mode = 1;
        send_pkt(8, 4'd4, 3'd7);
        idle(0);
        in_vld = 1'b0;
        n = 0;
        while (!(out_vld && mon_beat == 4) && n < 50) begin
            tick();
            n++;
        end
        check("beat4_reached", 64'(mon_beat), 64'(4));
        rst_n = 1'b0;
        tick();
        check("rst_mid_vld", 64'(out_vld), 64'(0));
        check("rst_mid_req", 64'(out_req), 64'(0));
        rst_n = 1'b1;
        model_reset();
        b0 = n_bursts;
        send_pkt(4, 4'd6, 3'd5);
        drain(100);
        check("post_rst_bursts", 64'(n_bursts - b0), 64'(1));

        do_reset();
        gnt_mode = 3;
        for (int p = 0; p < 40; p++) begin
            int len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++)
                send_word((i == 0 && $urandom_range(0, 7) != 0) || $urandom_range(0, 15) == 0, i == len - 1,
                          PORT_W'($urandom), PRI_W'($urandom));
            idle($urandom_range(0, 3));
        end
        gnt_mode = 1;
        drain(400);
        check("rand_ovf", 64'(err_ovf), 64'(m_ovf));
        check("rand_proto", 64'(err_proto), 64'(m_proto));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule
